// File: rtl/ibex_rvfi_trace_streamer_if.sv
// ibex_rvfi_trace_streamer_if: RVFI retirement bus plus the 32-bit trace word stream and status
interface ibex_rvfi_trace_streamer_if #(
    parameter int Depth = 8
);
    logic                   trace_en_i;
    logic                   rvfi_valid_i;
    logic [63:0]            rvfi_order_i;
    logic [31:0]            rvfi_insn_i;
    logic                   rvfi_trap_i;
    logic                   rvfi_halt_i;
    logic                   rvfi_intr_i;
    logic [1:0]             rvfi_mode_i;
    logic [4:0]             rvfi_rd_addr_i;
    logic [31:0]            rvfi_rd_wdata_i;
    logic [31:0]            rvfi_pc_rdata_i;
    logic [31:0]            rvfi_mem_addr_i;
    logic [3:0]             rvfi_mem_rmask_i;
    logic [3:0]             rvfi_mem_wmask_i;
    logic [31:0]            rvfi_mem_rdata_i;
    logic [31:0]            rvfi_mem_wdata_i;
    logic                   trace_valid_o;
    logic                   trace_ready_i;
    logic [31:0]            trace_data_o;
    logic                   trace_last_o;
    logic [$clog2(Depth):0] fifo_level_o;
    logic                   overflow_o;

    modport master (
        output trace_en_i, rvfi_valid_i, rvfi_order_i, rvfi_insn_i, rvfi_trap_i, rvfi_halt_i,
               rvfi_intr_i, rvfi_mode_i, rvfi_rd_addr_i, rvfi_rd_wdata_i, rvfi_pc_rdata_i,
               rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i, rvfi_mem_rdata_i,
               rvfi_mem_wdata_i, trace_ready_i,
        input  trace_valid_o, trace_data_o, trace_last_o, fifo_level_o, overflow_o
    );

    modport slave (
        input  trace_en_i, rvfi_valid_i, rvfi_order_i, rvfi_insn_i, rvfi_trap_i, rvfi_halt_i,
               rvfi_intr_i, rvfi_mode_i, rvfi_rd_addr_i, rvfi_rd_wdata_i, rvfi_pc_rdata_i,
               rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i, rvfi_mem_rdata_i,
               rvfi_mem_wdata_i, trace_ready_i,
        output trace_valid_o, trace_data_o, trace_last_o, fifo_level_o, overflow_o
    );
endinterface

// File: rtl/ibex_rvfi_trace_streamer.sv
// ibex_rvfi_trace_streamer: buffers RVFI retirements and streams them as 32-bit trace packets; IBEX_TRACE_STREAM_MEM_EN adds memory words
module ibex_rvfi_trace_streamer #(
    parameter int Depth    = 8,
    parameter int DropCntW = 8
) (
    input logic                       clk_i,
    input logic                       rst_i,
    ibex_rvfi_trace_streamer_if.slave bus
);
    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] Full = (AW+1)'(Depth);

    typedef struct packed {
`ifdef IBEX_TRACE_STREAM_MEM_EN
        logic        has_mem;
        logic [31:0] maddr;
        logic [31:0] mdata;
`endif
        logic        trap;
        logic        intr;
        logic        halt;
        logic [1:0]  mode;
        logic [4:0]  rd;
        logic [8:0]  order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
    } entry_t;

    typedef enum logic [2:0] {IDLE, HDR, PC, INSN, WDATA, MADDR, MDATA} state_t;

    state_t                state_q, state_d, done;
    entry_t                mem_q [Depth];
    entry_t                wr_e, head;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           level_q;
    logic [DropCntW-1:0]   drop_q, drop_d, drop_base, hdr_drop_q;
    logic                  overflow_q, valid, last, rdy, xfer, pop, push, push_req, drop, has_mem, more;
    logic [31:0]           data;
    logic                  unused_sink;

    assign rdy      = bus.trace_ready_i;
    assign push_req = bus.rvfi_valid_i & bus.trace_en_i;
    assign xfer     = valid & rdy;
    assign pop      = xfer & last;
    assign push     = push_req & (level_q < Full | pop);
    assign drop     = push_req & ~push;
    assign head     = mem_q[rd_ptr_q];
    // A packet ends with a pop, so the FIFO is non-empty afterwards iff it held more than one entry or a retirement arrives now.
    assign more     = level_q > (AW+1)'(1) || push_req;
    assign done     = more ? HDR : IDLE;

`ifdef IBEX_TRACE_STREAM_MEM_EN
    assign has_mem     = head.has_mem;
    assign unused_sink = ^bus.rvfi_order_i[63:9];
`else
    assign has_mem     = 1'b0;
    assign unused_sink = ^{bus.rvfi_order_i[63:9], bus.rvfi_mem_addr_i, bus.rvfi_mem_rmask_i,
                           bus.rvfi_mem_wmask_i, bus.rvfi_mem_rdata_i, bus.rvfi_mem_wdata_i};
`endif

    // Pack the incoming retirement into a FIFO entry.
    always_comb begin
        wr_e       = '0;
        wr_e.trap  = bus.rvfi_trap_i;
        wr_e.intr  = bus.rvfi_intr_i;
        wr_e.halt  = bus.rvfi_halt_i;
        wr_e.mode  = bus.rvfi_mode_i;
        wr_e.rd    = bus.rvfi_rd_addr_i;
        wr_e.order = bus.rvfi_order_i[8:0];
        wr_e.pc    = bus.rvfi_pc_rdata_i;
        wr_e.insn  = bus.rvfi_insn_i;
        wr_e.wdata = bus.rvfi_rd_wdata_i;
`ifdef IBEX_TRACE_STREAM_MEM_EN
        wr_e.has_mem = |(bus.rvfi_mem_rmask_i | bus.rvfi_mem_wmask_i);
        wr_e.maddr   = bus.rvfi_mem_addr_i;
        wr_e.mdata   = |bus.rvfi_mem_wmask_i ? bus.rvfi_mem_wdata_i : bus.rvfi_mem_rdata_i;
`endif
    end

    // Entry storage; contents need no reset since the level gates every read.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_e;
    end

    // Packet sequencer: each state presents one word of the head entry and advances on transfer.
    always_comb begin
        state_d = state_q;
        valid   = 1'b1;
        data    = '0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                valid   = 1'b0;
                state_d = push_req ? HDR : IDLE;
            end
            HDR: begin
                data    = {4'hA, head.trap, head.intr, head.halt, has_mem, 8'(hdr_drop_q), head.rd, head.mode, head.order};
                state_d = rdy ? PC : HDR;
            end
            PC: begin
                data    = head.pc;
                state_d = rdy ? INSN : PC;
            end
            INSN: begin
                data    = head.insn;
                last    = head.rd == 5'd0 && !has_mem;
                state_d = !rdy ? INSN : head.rd != 5'd0 ? WDATA : has_mem ? MADDR : done;
            end
            WDATA: begin
                data    = head.wdata;
                last    = !has_mem;
                state_d = !rdy ? WDATA : has_mem ? MADDR : done;
            end
`ifdef IBEX_TRACE_STREAM_MEM_EN
            MADDR: begin
                data    = head.maddr;
                state_d = rdy ? MDATA : MADDR;
            end
            MDATA: begin
                data    = head.mdata;
                last    = 1'b1;
                state_d = rdy ? done : MDATA;
            end
`endif
            default: begin
                valid   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // A header transfer retires the count it reported; drops seen while it stalled stay pending.
    always_comb begin
        drop_base = (xfer && state_q == HDR) ? drop_q - hdr_drop_q : drop_q;
        drop_d    = (drop && drop_base != '1) ? drop_base + DropCntW'(1) : drop_base;
    end

    // State, pointers, level and drop bookkeeping; the header count is frozen when a header is first presented.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= '0;
            hdr_drop_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_q + (AW+1)'(push) - (AW+1)'(pop);
            drop_q     <= drop_d;
            overflow_q <= overflow_q | drop;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (state_d == HDR && state_q != HDR) hdr_drop_q <= drop_d;
        end
    end

    assign bus.trace_valid_o = valid;
    assign bus.trace_data_o  = data;
    assign bus.trace_last_o  = last;
    assign bus.fifo_level_o  = level_q;
    assign bus.overflow_o    = overflow_q;
endmodule
